// File: rtl/nios_setup_onchip_ram_pipelined_pkg.sv
// Shared types and constants for the Nios on-chip scratch RAM.
// Imported by the RAM top level and its storage array.
package nios_setup_ram_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } ram_state_t;

    localparam int MAX_READ_LATENCY = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/nios_setup_onchip_ram_pipelined_if.sv
// Avalon-MM slave bundle for the on-chip RAM.
// The master side drives requests; the slave side returns data and stalls.
interface nios_setup_onchip_ram_pipelined_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                  chipselect;
    logic [ADDR_W-1:0]     address;
    logic                  read;
    logic                  write;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output chipselect, address, read, write,
        output byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, address, read, write,
        input  byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/nios_setup_ram_array.sv
// Inferable byte-enabled single-port RAM with synchronous read.
// The read register only loads on a read strobe so it holds between reads.
module nios_setup_ram_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                re,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (ce) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (ce && re) rdata <= mem[addr];
    end
endmodule

// File: rtl/nios_setup_onchip_ram_pipelined.sv
// Pipelined Avalon-MM on-chip RAM with waitrequest and a zero-clear sweep.
// Holds the FSM, clear counter, accept logic and read-valid pipeline.
module nios_setup_onchip_ram_pipelined
    import nios_setup_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_req,
    input  logic clken,
    nios_setup_onchip_ram_pipelined_if.slave bus,
    output logic init_done
);
    localparam int BE_W = DATA_W/8;
    localparam int LAT  = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                          (READ_LATENCY < 1) ? 1 : READ_LATENCY;

    ram_state_t        state, state_nx;
    logic [ADDR_W-1:0] clr_addr, clr_addr_nx;
    logic              en, wr_acc, rd_acc, ram_ce;
    logic [BE_W-1:0]   ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic [LAT-1:0]    vld;

    assign en              = clken & ~reset_req;
    assign bus.waitrequest = (state == CLEAR) | ~en;
    assign init_done       = (state == READY);
    assign wr_acc = bus.chipselect & bus.write & ~bus.waitrequest;
    assign rd_acc = bus.chipselect & bus.read & ~bus.write & ~bus.waitrequest;
    // Reset never writes the array; only the sweep clears it.
    assign ram_ce = en & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_addr <= '0;
        end else if (en) begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        ram_addr    = bus.address;
        ram_wdata   = bus.writedata;
        ram_we      = wr_acc ? bus.byteenable : '0;
        unique case (state)
            CLEAR: begin
                ram_addr    = clr_addr;
                ram_wdata   = '0;
                ram_we      = '1;
                clr_addr_nx = clr_addr + ADDR_W'(1);
                if (&clr_addr) state_nx = READY;
            end
            READY: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) vld <= '0;
        else if (en) vld <= LAT'({vld, rd_acc});
    end

    assign bus.readdatavalid = vld[LAT-1];

    nios_setup_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (reset),
        .ce    (ram_ce),
        .re    (rd_acc),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    if (LAT == 1) begin : g_lat1
        assign bus.readdata = ram_rdata;
    end else begin : g_lat2
        logic [DATA_W-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (reset) rd_q <= '0;
            else if (en && vld[0]) rd_q <= ram_rdata;
        end
        assign bus.readdata = rd_q;
    end
endmodule
